// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_pkg                                                      |
// | Description : Shared definitions for the 16-point FFT path: frame size,     |
// |               sample counter width, frame sequencer state encoding and the  |
// |               radix-2 twiddle-factor constants used by the FFT.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_CNT_W = 4;
  localparam int FFT_FRM_W = 8;
  localparam int FFT_TW_W  = 16;

  // Frame sequencer states.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } fft_state_e;

  // W_16^k = exp(-j*2*pi*k/16) for k = 0..7, Q1.15 signed.
  // Full scale +1.0 is saturated to 32767.
  function automatic logic signed [FFT_TW_W-1:0] twiddle_re(input logic [2:0] k);
    logic signed [FFT_TW_W-1:0] v;
    v = '0;
    case (k)
      3'd0: v = 16'sd32767;
      3'd1: v = 16'sd30274;
      3'd2: v = 16'sd23170;
      3'd3: v = 16'sd12540;
      3'd4: v = 16'sd0;
      3'd5: v = -16'sd12540;
      3'd6: v = -16'sd23170;
      3'd7: v = -16'sd30274;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic signed [FFT_TW_W-1:0] twiddle_im(input logic [2:0] k);
    logic signed [FFT_TW_W-1:0] v;
    v = '0;
    case (k)
      3'd0: v = 16'sd0;
      3'd1: v = -16'sd12540;
      3'd2: v = -16'sd23170;
      3'd3: v = -16'sd30274;
      3'd4: v = -16'sd32767;
      3'd5: v = -16'sd30274;
      3'd6: v = -16'sd23170;
      3'd7: v = -16'sd12540;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_frame_ctrl                                               |
// | Description : Frame sequencer between the FIR output and the 16-point FFT.  |
// |               Gates the FFT window shift register on accepted samples,     |
// |               freezes it after N samples and flags the FFT outputs valid   |
// |               until the downstream analyser takes the frame.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   clock, rising edge                                       |
// |   rst        in   synchronous active-high reset                            |
// |   fir_valid  in   FIR sample offered this cycle                            |
// |   fir_ready  out  sample will be accepted this cycle (FILL)                |
// |   abort      in   discard partial/held frame, restart filling              |
// |   out_ready  in   analyser consumes the held frame (HOLD only)             |
// |   win_shift  out  FFT window shift enable = fir_valid & fir_ready          |
// |   fft_valid  out  window full and frozen, FFT outputs valid (HOLD)         |
// |   sample_cnt out  samples held in the current frame                        |
// |   frame_cnt  out  frames handed off, wraps                                 |
// |   overrun    out  sticky: sample offered while not ready                    |
// +----------------------------------------------------------------------------+
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int CNT_W = FFT_CNT_W,
  parameter int FRM_W = FFT_FRM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fir_valid,
  output logic             fir_ready,
  input  logic             abort,
  input  logic             out_ready,
  output logic             win_shift,
  output logic             fft_valid,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  fft_state_e       r_state;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [FRM_W-1:0] r_frame_cnt;
  logic             r_overrun;
  logic             w_fir_ready;

  // Handshake outputs decode straight from the registered state so they are
  // glitch-free and available from the first cycle after any edge.
  assign w_fir_ready = (r_state == FILL);
  assign fir_ready   = w_fir_ready;
  assign fft_valid   = (r_state == HOLD);
  // An abort-cycle sample still shifts the window; it is simply not counted,
  // and the following N counted samples overwrite it.
  assign win_shift   = fir_valid & w_fir_ready;

  assign sample_cnt  = r_sample_cnt;
  assign frame_cnt   = r_frame_cnt;
  assign overrun     = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_sample_cnt <= '0;
      r_frame_cnt  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      // A dropped sample is recorded regardless of abort/handoff in that cycle.
      if (fir_valid && !w_fir_ready) begin
        r_overrun <= 1'b1;
      end

      if (abort) begin
        r_state      <= FILL;
        r_sample_cnt <= '0;
      end else begin
        case (r_state)
          FILL: begin
            if (fir_valid) begin
              if (r_sample_cnt == C_LAST) begin
                r_state      <= HOLD;
                r_sample_cnt <= '0;
              end else begin
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
              end
            end
          end
          HOLD: begin
            if (out_ready) begin
              r_state     <= FILL;
              r_frame_cnt <= r_frame_cnt + FRM_W'(1);
            end
          end
          default: begin
            r_state      <= FILL;
            r_sample_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule : fft_frame_ctrl
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_frame_ctrl                                            |
// | Description : Directed self-checking bench for fft_frame_ctrl, with a      |
// |               behavioural FFT window register to check bin 0.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fir_valid;
  logic       fir_ready;
  logic       abort;
  logic       out_ready;
  logic       win_shift;
  logic       fft_valid;
  logic [3:0] sample_cnt;
  logic [7:0] frame_cnt;
  logic       overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] fir_d;
  logic [31:0] win [16];

  always #5 clk = ~clk;

  fft_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fir_valid  (fir_valid),
    .fir_ready  (fir_ready),
    .abort      (abort),
    .out_ready  (out_ready),
    .win_shift  (win_shift),
    .fft_valid  (fft_valid),
    .sample_cnt (sample_cnt),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun)
  );

  // Behavioural FFT window register, enabled by the DUT's shift strobe.
  always @(posedge clk) begin
    if (win_shift) begin
      for (int k = 15; k > 0; k--) win[k] <= win[k-1];
      win[0] <= fir_d;
    end
  end

  // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: offer n consecutive samples while in FILL.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      fir_valid = 1'b1;
      fir_d     = 32'h0001_0000;
      tick();
    end
    fir_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fir_valid = 1'b1; abort = 1'b0; out_ready = 1'b0; fir_d = '0;
    tick();
    tick();
    #1;
    n_cmp++; if (fir_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fir_ready: got %b expected 1", fir_ready); end
    n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fft_valid: got %b expected 0", fft_valid); end
    n_cmp++; if (sample_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_sample_cnt: got %0d expected 0", sample_cnt); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_cmp++; if (win_shift !== 1'b1) begin n_fail++; $display("FAIL reset_win_shift: got %b expected 1", win_shift); end
    tick();
    rst = 1'b0; fir_valid = 1'b0;
  endtask

  task automatic test_fill();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1; fir_d = 32'h0001_0000;
      #1;
      if (win_shift) pulses++;
      n_cmp++; if (sample_cnt !== 4'(i)) begin n_fail++; $display("FAIL fill_cnt: got %0d expected %0d", sample_cnt, i); end
      n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid: got %b expected 0 at sample %0d", fft_valid, i); end
      tick();
    end
    fir_valid = 1'b0;
    #1;
    n_cmp++; if (pulses != 16) begin n_fail++; $display("FAIL fill_pulses: got %0d expected 16", pulses); end
    n_cmp++; if (fft_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b expected 1", fft_valid); end
    n_cmp++; if (sample_cnt !== 4'd0) begin n_fail++; $display("FAIL fill_cnt_wrap: got %0d expected 0", sample_cnt); end
    n_cmp++; if (fir_ready !== 1'b0) begin n_fail++; $display("FAIL fill_hold_ready: got %b expected 0", fir_ready); end
    tick();
  endtask

  task automatic test_hold_backpressure();
    for (int i = 0; i < 5; i++) begin
      fir_valid = 1'b1; fir_d = 32'hBAD0_0000;
      #1;
      n_cmp++; if (win_shift !== 1'b0) begin n_fail++; $display("FAIL hold_win_shift: got %b expected 0", win_shift); end
      n_cmp++; if (fft_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", fft_valid); end
      tick();
    end
    fir_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL hold_overrun: got %b expected 1", overrun); end
    n_cmp++; if (sample_cnt !== 4'd0) begin n_fail++; $display("FAIL hold_cnt: got %0d expected 0", sample_cnt); end
    n_cmp++; if (fir_ready !== 1'b0) begin n_fail++; $display("FAIL hold_handoff_ready: got %b expected 0", fir_ready); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL hold_frame_before: got %0d expected 0", frame_cnt); end
    tick();
    out_ready = 1'b0;
    #1;
    n_cmp++; if (fir_ready !== 1'b1) begin n_fail++; $display("FAIL handoff_ready: got %b expected 1", fir_ready); end
    n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL handoff_valid: got %b expected 0", fft_valid); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL handoff_frame: got %0d expected 1", frame_cnt); end
    // out_ready in FILL must be ignored.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL fill_out_ready: got %0d expected 1", frame_cnt); end
    n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL fill_out_ready_valid: got %b expected 0", fft_valid); end
  endtask

  task automatic test_gapped();
    int accepted;
    int cycles;
    logic [31:0] sum;
    accepted = 0;
    cycles   = 0;
    for (int k = 0; k < 16; k++) win[k] = 32'h7777_0000;
    while (accepted < 16 && cycles < 400) begin
      fir_valid = 1'($urandom_range(0, 1));
      fir_d     = fir_valid ? 32'h0001_0000 : 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid: got %b expected 0 after %0d", fft_valid, accepted); end
      n_cmp++; if (sample_cnt !== 4'(accepted)) begin n_fail++; $display("FAIL gap_cnt: got %0d expected %0d", sample_cnt, accepted); end
      if (win_shift) accepted++;
      cycles++;
      tick();
    end
    fir_valid = 1'b0;
    #1;
    n_cmp++; if (accepted != 16) begin n_fail++; $display("FAIL gap_timeout: got %0d expected 16 accepted", accepted); end
    n_cmp++; if (fft_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b expected 1", fft_valid); end
    sum = '0;
    for (int k = 0; k < 16; k++) sum += win[k];
    n_cmp++; if (sum !== 32'h0010_0000) begin n_fail++; $display("FAIL gap_bin0: got %h expected 00100000", sum); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    n_cmp++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL gap_frame: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_abort();
    feed(7);
    #1;
    n_cmp++; if (sample_cnt !== 4'd7) begin n_fail++; $display("FAIL abort_pre_cnt: got %0d expected 7", sample_cnt); end
    abort = 1'b1; fir_valid = 1'b1;
    #1;
    n_cmp++; if (win_shift !== 1'b1) begin n_fail++; $display("FAIL abort_win_shift: got %b expected 1", win_shift); end
    tick();
    abort = 1'b0; fir_valid = 1'b0;
    #1;
    n_cmp++; if (sample_cnt !== 4'd0) begin n_fail++; $display("FAIL abort_cnt: got %0d expected 0", sample_cnt); end
    n_cmp++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_frame: got %0d expected 2", frame_cnt); end
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1;
      #1;
      n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL abort_early_valid: got %b expected 0 at %0d", fft_valid, i); end
      tick();
    end
    fir_valid = 1'b0;
    #1;
    n_cmp++; if (fft_valid !== 1'b1) begin n_fail++; $display("FAIL abort_refill_valid: got %b expected 1", fft_valid); end
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL abort_hold_valid: got %b expected 0", fft_valid); end
    n_cmp++; if (fir_ready !== 1'b1) begin n_fail++; $display("FAIL abort_hold_ready: got %b expected 1", fir_ready); end
    n_cmp++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_hold_frame: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int drops;
    drops = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0; fir_valid = 1'b1; out_ready = 1'b1; fir_d = 32'h0001_0000;
    for (int c = 0; c < 256 * 17; c++) begin
      #1;
      if (fir_valid && !fir_ready) drops++;
      n_cmp++; if (fft_valid !== ((c % 17) == 16)) begin n_fail++; $display("FAIL b2b_valid: got %b at cycle %0d", fft_valid, c); end
      n_cmp++; if (frame_cnt !== 8'((c / 17) % 256)) begin n_fail++; $display("FAIL b2b_frame: got %0d expected %0d", frame_cnt, (c / 17) % 256); end
      tick();
    end
    fir_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap: got %0d expected 0", frame_cnt); end
    n_cmp++; if (drops != 256) begin n_fail++; $display("FAIL b2b_drops: got %0d expected 256", drops); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
  endtask

  task automatic test_mid_reset();
    feed(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (sample_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_fill_cnt: got %0d expected 0", sample_cnt); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_fill_overrun: got %b expected 0", overrun); end
    n_cmp++; if (fir_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fill_ready: got %b expected 1", fir_ready); end
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1;
      #1;
      n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL rst_refill_early: got %b expected 0 at %0d", fft_valid, i); end
      tick();
    end
    fir_valid = 1'b0;
    #1;
    n_cmp++; if (fft_valid !== 1'b1) begin n_fail++; $display("FAIL rst_refill_valid: got %b expected 1", fft_valid); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    feed(16);
    #1;
    n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL rst_pre_frame: got %0d expected 1", frame_cnt); end
    // Reset in HOLD, with a sample offered that would otherwise set overrun.
    rst = 1'b1; fir_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; fir_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid: got %b expected 0", fft_valid); end
    n_cmp++; if (fir_ready !== 1'b1) begin n_fail++; $display("FAIL rst_hold_ready: got %b expected 1", fir_ready); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_hold_frame: got %0d expected 0", frame_cnt); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_hold_overrun: got %b expected 0", overrun); end
    feed(15);
    #1;
    n_cmp++; if (fft_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_15: got %b expected 0", fft_valid); end
    feed(1);
    #1;
    n_cmp++; if (fft_valid !== 1'b1) begin n_fail++; $display("FAIL rst_hold_16: got %b expected 1", fft_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold_backpressure();
    test_gapped();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fft_frame_ctrl
`default_nettype wire
